qcl_ddr_rx_align: RTL

Parametrised multi-lane DDR receive back-end with per-lane word alignment. It takes per-lane DDR bit pairs (rise/fall) already captured by the IO primitive. It deserialises each lane into deser_p-bit words through a shared gearbox, then trains each lane's bit-slip offset against a known pattern until lock. It sits between the IDDR capture stage and the link-layer word consumer, and replaces fixed-width DDR capture with alignment-aware parallel output.

---
 rtl/qcl_ddr_rx_align_if.sv | 26 ++
 rtl/qcl_ddr_rx_align.sv | 137 +++++++++++++
 2 files changed

// File: rtl/qcl_ddr_rx_align_if.sv
// Bundle between the IDDR capture stage and the aligning receive back-end.
// The master drives lane pairs and retrain; the slave returns aligned words and status.
interface qcl_ddr_rx_align_if #(
  parameter int channels_p = 16,
  parameter int deser_p    = 8
);
  localparam int off_w_lp = $clog2(deser_p);

  logic [2*channels_p-1:0]        data_i;
  logic                           retrain_i;
  logic [channels_p*deser_p-1:0]  data_par_o;
  logic                           valid_o;
  logic [channels_p-1:0]          aligned_o;
  logic [channels_p-1:0]          fail_o;
  logic [channels_p*off_w_lp-1:0] offset_o;

  modport master (
    output data_i, retrain_i,
    input  data_par_o, valid_o, aligned_o, fail_o, offset_o
  );

  modport slave (
    input  data_i, retrain_i,
    output data_par_o, valid_o, aligned_o, fail_o, offset_o
  );
endinterface

// File: rtl/qcl_ddr_rx_align.sv
// Multi-lane DDR deserialiser with a shared word gearbox and per-lane bit-slip training.
// Each lane slides its word window over a 2*deser_p bit history until the training word repeats.
module qcl_ddr_rx_align #(
  parameter int                 channels_p      = 16,
  parameter int                 deser_p         = 8,
  parameter logic [deser_p-1:0] train_pattern_p = 8'hF0,
  parameter int                 lock_count_p    = 4
) (
  input logic               clk_i,
  input logic               reset_i,
  qcl_ddr_rx_align_if.slave rx
);
  localparam int off_w_lp   = $clog2(deser_p);
  localparam int hist_w_lp  = 2 * deser_p;
  localparam int phase_w_lp = (deser_p / 2 > 1) ? $clog2(deser_p / 2) : 1;
  localparam int match_w_lp = $clog2(lock_count_p + 1);

  localparam logic [phase_w_lp-1:0] phase_last_lp = phase_w_lp'(deser_p / 2 - 1);
  localparam logic [off_w_lp-1:0]   off_last_lp   = off_w_lp'(deser_p - 1);
  localparam logic [match_w_lp-1:0] match_last_lp = match_w_lp'(lock_count_p - 1);

  // state     | meaning
  // st_search | compare each word with the training pattern at the current offset
  // st_settle | drop one word after a slip, the window straddles old and new offset
  // st_locked | offset frozen until retrain or reset
  localparam logic [1:0] st_search = 2'd0;
  localparam logic [1:0] st_settle = 2'd1;
  localparam logic [1:0] st_locked = 2'd2;

  logic [phase_w_lp-1:0]         phase_q;
  logic                          word_stb_q;
  logic                          primed_q;
  logic                          valid_q;
  logic [channels_p*deser_p-1:0] data_par_q;
  logic [hist_w_lp-1:0]          hist_q  [channels_p];
  logic [deser_p-1:0]            word    [channels_p];
  logic [1:0]                    state_q [channels_p];
  logic [1:0]                    state_d [channels_p];
  logic [off_w_lp-1:0]           off_q   [channels_p];
  logic [off_w_lp-1:0]           off_d   [channels_p];
  logic [off_w_lp-1:0]           slip_q  [channels_p];
  logic [off_w_lp-1:0]           slip_d  [channels_p];
  logic [match_w_lp-1:0]         match_q [channels_p];
  logic [match_w_lp-1:0]         match_d [channels_p];
  logic [channels_p-1:0]         fail_q;
  logic [channels_p-1:0]         fail_d;
  logic                          eval;

  // The first word after reset is half reset-cleared history, so it is not trained on.
  assign eval = word_stb_q & primed_q;

  always_comb begin
    fail_d = fail_q;
    for (int c = 0; c < channels_p; c++) begin
      word[c]    = hist_q[c][off_q[c] +: deser_p];
      state_d[c] = state_q[c];
      off_d[c]   = off_q[c];
      slip_d[c]  = slip_q[c];
      match_d[c] = match_q[c];
      if (rx.retrain_i) begin
        state_d[c] = st_search;
        slip_d[c]  = '0;
        match_d[c] = '0;
        fail_d[c]  = 1'b0;
      end else if (eval) begin
        case (state_q[c])
          st_search: begin
            if (word[c] == train_pattern_p) begin
              if (match_q[c] == match_last_lp) begin
                state_d[c] = st_locked;
                match_d[c] = '0;
              end else begin
                match_d[c] = match_q[c] + match_w_lp'(1);
              end
            end else begin
              match_d[c] = '0;
              off_d[c]   = (off_q[c] == off_last_lp) ? '0 : off_q[c] + off_w_lp'(1);
              state_d[c] = st_settle;
              if (slip_q[c] == off_last_lp) begin
                slip_d[c] = '0;
                fail_d[c] = 1'b1;
              end else begin
                slip_d[c] = slip_q[c] + off_w_lp'(1);
              end
            end
          end
          st_settle: state_d[c] = st_search;
          st_locked: state_d[c] = st_locked;
          default:   state_d[c] = st_search;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q    <= '0;
      word_stb_q <= 1'b0;
      primed_q   <= 1'b0;
      valid_q    <= 1'b0;
      data_par_q <= '0;
      fail_q     <= '0;
      for (int c = 0; c < channels_p; c++) begin
        hist_q[c]  <= '0;
        state_q[c] <= st_search;
        off_q[c]   <= '0;
        slip_q[c]  <= '0;
        match_q[c] <= '0;
      end
    end else begin
      phase_q    <= (phase_q == phase_last_lp) ? '0 : phase_q + phase_w_lp'(1);
      word_stb_q <= (phase_q == phase_last_lp);
      primed_q   <= primed_q | word_stb_q;
      valid_q    <= word_stb_q;
      fail_q     <= fail_d;
      for (int c = 0; c < channels_p; c++) begin
        hist_q[c]  <= {rx.data_i[2*c+1], rx.data_i[2*c], hist_q[c][hist_w_lp-1:2]};
        state_q[c] <= state_d[c];
        off_q[c]   <= off_d[c];
        slip_q[c]  <= slip_d[c];
        match_q[c] <= match_d[c];
        if (word_stb_q) begin
          data_par_q[c*deser_p +: deser_p] <= word[c];
        end
      end
    end
  end

  assign rx.data_par_o = data_par_q;
  assign rx.valid_o    = valid_q;
  assign rx.fail_o     = fail_q;

  for (genvar c = 0; c < channels_p; c++) begin : g_lane_out
    assign rx.aligned_o[c]                         = (state_q[c] == st_locked);
    assign rx.offset_o[c*off_w_lp +: off_w_lp]     = off_q[c];
  end
endmodule
